ads131_frame_reader: RTL and testbench

- Downstream data stage for the ADS131A0x SPI master, used once ADC init has completed (adc_init_completed high).
- On each ADC data-ready event it runs one SPI frame: status word followed by NUM_CHANNELS channel words.
- It sends an optional command in the first word and deserialises MISO.
- Results are presented as per-channel samples on a valid/ready handshake for the downstream sample FIFO/DSP logic.

---
 rtl/ads131_pkg.sv | 9 +
 rtl/spi_sclk_gen.sv | 29 ++
 rtl/ads131_frame_reader.sv | 139 +++++++++++++
 tb/tb_ads131_frame_reader.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/ads131_pkg.sv
// ads131_pkg: shared FSM states, SPI mode and sizing constants for the ADS131A0x frame reader
package ads131_pkg;
  typedef enum logic [1:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD} state_t;
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b1;
  localparam int STATUS_BITS = 16;
  localparam int MAX_CHANNELS = 8;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: SCLK divider with one-cycle edge strobes, held at idle level while run is low
module spi_sclk_gen
  import ads131_pkg::*;
#(
  parameter int SCLK_DIV = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic sclk,
  output logic rise_evt,
  output logic fall_evt
);
  localparam int DW = $clog2(SCLK_DIV + 1);
  logic [DW-1:0] div;
  logic tick;
  assign tick = run && div == DW'(SCLK_DIV - 1);
  assign rise_evt = tick && sclk == SPI_CPOL;
  assign fall_evt = tick && sclk != SPI_CPOL;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      sclk <= SPI_CPOL;
    end else begin
      div <= (run && !tick) ? div + 1'b1 : '0;
      sclk <= !run ? SPI_CPOL : tick ? ~sclk : sclk;
    end
  end
endmodule

// File: rtl/ads131_frame_reader.sv
// ads131_frame_reader: DRDY-triggered SPI frame reader (status + channel words) with sample handshake
// Optional trailing CRC word output enabled by ADS131_CRC_WORD_EN
module ads131_frame_reader
  import ads131_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int WORD_BITS = 24,
  parameter int SCLK_DIV = 6
) (
  input  logic                            system_clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            adc_drdy_n,
  input  logic [15:0]                     cmd_word,
  input  logic                            SPI_MISO,
  output logic                            SPI_MOSI,
  output logic                            SPI_CS,
  output logic                            SPI_SCLK,
  output logic [STATUS_BITS-1:0]          status_word,
  output logic                            status_valid,
  output logic [WORD_BITS-1:0]            sample_data,
  output logic [$clog2(MAX_CHANNELS)-1:0] sample_channel,
  output logic                            sample_valid,
  input  logic                            sample_ready,
  output logic                            busy,
  output logic                            overrun
`ifdef ADS131_CRC_WORD_EN
  ,output logic [15:0]                    crc_word,
  output logic                            crc_valid
`endif
);
`ifdef ADS131_CRC_WORD_EN
  localparam int WORDS = NUM_CHANNELS + 2;
`else
  localparam int WORDS = NUM_CHANNELS + 1;
`endif
  localparam int DW = $clog2(SCLK_DIV + 1);
  localparam int BW = $clog2(WORD_BITS);
  localparam int CW = $clog2(MAX_CHANNELS);
  state_t state, next;
  logic [SYNC_DEPTH-1:0] sync;
  logic drdy_q, trig, rise, fall, launch, capture, last_bit, last_word, cnt_end, done, is_crc;
  logic [DW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [3:0] word_cnt, done_word;
  logic [WORD_BITS-1:0] tx, rx;
  spi_sclk_gen #(.SCLK_DIV(SCLK_DIV)) u_sclk (
    .clk(system_clock), .rst(reset), .run(state == SHIFT),
    .sclk(SPI_SCLK), .rise_evt(rise), .fall_evt(fall)
  );
  assign trig = drdy_q && !sync[SYNC_DEPTH-1];
  assign launch = SPI_CPHA ? rise : fall;
  assign capture = SPI_CPHA ? fall : rise;
  assign last_bit = bit_cnt == BW'(WORD_BITS - 1);
  assign last_word = word_cnt == 4'(WORDS - 1);
  assign cnt_end = cnt == DW'(SCLK_DIV - 1);
`ifdef ADS131_CRC_WORD_EN
  assign is_crc = done_word == 4'(WORDS - 1);
`else
  assign is_crc = 1'b0;
`endif
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:     next = (trig && enable) ? CS_SETUP : IDLE;
      CS_SETUP: next = cnt_end ? SHIFT : CS_SETUP;
      SHIFT:    next = (capture && last_bit && last_word) ? CS_HOLD : SHIFT;
      CS_HOLD:  next = cnt_end ? IDLE : CS_HOLD;
      default:  next = IDLE;
    endcase
  end
  always_ff @(posedge system_clock or posedge reset) begin
    if (reset) begin
      sync <= '1;
      drdy_q <= 1'b1;
      SPI_CS <= 1'b1;
      SPI_MOSI <= 1'b0;
      busy <= 1'b0;
      overrun <= 1'b0;
      cnt <= '0;
      bit_cnt <= '0;
      word_cnt <= '0;
      done <= 1'b0;
      done_word <= '0;
      tx <= '0;
      rx <= '0;
      status_word <= '0;
      status_valid <= 1'b0;
      sample_data <= '0;
      sample_channel <= '0;
      sample_valid <= 1'b0;
`ifdef ADS131_CRC_WORD_EN
      crc_word <= '0;
      crc_valid <= 1'b0;
`endif
    end else begin
      sync <= {sync[SYNC_DEPTH-2:0], adc_drdy_n};
      drdy_q <= sync[SYNC_DEPTH-1];
      SPI_CS <= next == IDLE;
      busy <= next != IDLE;
      cnt <= (state == next && (state == CS_SETUP || state == CS_HOLD)) ? cnt + 1'b1 : '0;
      if (trig && busy) overrun <= 1'b1;
      if (state == IDLE && next == CS_SETUP) begin
        tx <= WORD_BITS'(cmd_word) << (WORD_BITS - 16);
        SPI_MOSI <= cmd_word[15];
        bit_cnt <= '0;
        word_cnt <= '0;
      end
      if (launch) SPI_MOSI <= tx[WORD_BITS-1];
      // tx drains to zero after word 0, so later words send zeros
      if (capture) begin
        rx <= {rx[WORD_BITS-2:0], SPI_MISO};
        tx <= tx << 1;
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        word_cnt <= last_bit ? word_cnt + 1'b1 : word_cnt;
        if (last_bit) done_word <= word_cnt;
      end
      done <= capture && last_bit;
      status_valid <= done && done_word == 4'd0;
      if (done && done_word == 4'd0) status_word <= rx[WORD_BITS-1 -: STATUS_BITS];
`ifdef ADS131_CRC_WORD_EN
      crc_valid <= done && is_crc;
      if (done && is_crc) crc_word <= rx[WORD_BITS-1 -: 16];
`endif
      if (done && done_word != 4'd0 && !is_crc) begin
        sample_data <= rx;
        sample_channel <= CW'(done_word - 4'd1);
        sample_valid <= 1'b1;
        if (sample_valid && !sample_ready) overrun <= 1'b1;
      end else if (sample_ready) begin
        sample_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ads131_frame_reader.sv
// tb_ads131_frame_reader: scoreboard bench with a mode-1 ADC model for ads131_frame_reader
module tb_ads131_frame_reader;
  logic clk = 0, rst = 1, enable = 0, drdy_n = 1, miso = 0, ready = 1;
  logic [15:0] cmd = 16'h0000;
  logic mosi, cs, sclk, status_valid, sample_valid, busy, overrun;
  logic [15:0] status_word;
  logic [23:0] sample_data;
  logic [2:0] sample_channel;

  ads131_frame_reader dut (
    .system_clock(clk), .reset(rst), .enable(enable), .adc_drdy_n(drdy_n),
    .cmd_word(cmd), .SPI_MISO(miso), .SPI_MOSI(mosi), .SPI_CS(cs), .SPI_SCLK(sclk),
    .status_word(status_word), .status_valid(status_valid), .sample_data(sample_data),
    .sample_channel(sample_channel), .sample_valid(sample_valid), .sample_ready(ready),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  typedef struct packed {logic [2:0] ch; logic [23:0] data;} samp_t;
  samp_t sq[$];
  logic [15:0] stq[$];
  samp_t e;

  always @(negedge clk) if (!rst) begin
    if (status_valid) begin
      if (stq.size() == 0) begin
        checks++; errors++;
        $display("FAIL status_extra: got 0x%0h expected none", status_word);
      end else chk("status_word", 32'(status_word), 32'(stq.pop_front()));
    end
    if (sample_valid && ready) begin
      if (sq.size() == 0) begin
        checks++; errors++;
        $display("FAIL sample_extra: got ch%0d 0x%0h expected none", sample_channel, sample_data);
      end else begin
        e = sq.pop_front();
        chk("sample_channel", 32'(sample_channel), 32'(e.ch));
        chk("sample_data", 32'(sample_data), 32'(e.data));
      end
    end
  end

  logic [119:0] fbits = '0;
  logic [23:0] mosi_w0;
  logic psclk = 0, pcs = 1;
  int idx, falls, frames = 0, cs_cnt, cyc = 0, last_rise, pmin, pmax, mosi_ones;
  always @(negedge clk) begin
    cyc++;
    if (pcs && !cs) begin
      frames++; idx = 0; falls = 0; cs_cnt = 0; mosi_w0 = '0; mosi_ones = 0;
      pmin = 1000; pmax = 0; last_rise = -1;
    end
    if (!cs) cs_cnt++;
    if (!cs && !psclk && sclk) begin
      if (idx < 120) miso = fbits[119-idx];
      idx++;
      if (last_rise >= 0) begin
        if (cyc - last_rise < pmin) pmin = cyc - last_rise;
        if (cyc - last_rise > pmax) pmax = cyc - last_rise;
      end
      last_rise = cyc;
    end
    if (!cs && psclk && !sclk) begin
      if (falls < 24) mosi_w0 = {mosi_w0[22:0], mosi};
      else if (mosi) mosi_ones++;
      falls++;
    end
    psclk = sclk;
    pcs = cs;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; tick(3); rst = 0; tick(2);
  endtask

  task automatic set_frame(logic [15:0] st, logic [23:0] a, logic [23:0] b,
                           logic [23:0] c, logic [23:0] d, bit expect_all);
    fbits = {st, 8'h00, a, b, c, d};
    if (expect_all) begin
      stq.push_back(st);
      sq.push_back({3'd0, a}); sq.push_back({3'd1, b});
      sq.push_back({3'd2, c}); sq.push_back({3'd3, d});
    end
  endtask

  task automatic start_frame();
    int n = 0;
    drdy_n = 0;
    while (!busy && n < 20) begin tick(1); n++; end
    chk("frame_start", 32'(busy), 32'd1);
    drdy_n = 1;
  endtask

  task automatic end_frame();
    int n = 0;
    while (busy && n < 2000) begin tick(1); n++; end
    chk("frame_end", 32'(busy), 32'd0);
    tick(10);
  endtask

  int f0;
  initial begin
    tick(3);
    chk("rst_cs", 32'(cs), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_flags", 32'({busy, sample_valid, status_valid, overrun}), 32'd0);
    chk("rst_data", 32'({status_word, sample_data, sample_channel}), 32'd0);
    rst = 0; tick(3); enable = 1;

    set_frame(16'h2200, 24'h000001, 24'h7FFFFF, 24'h800000, 24'hABCDEF, 1);
    f0 = frames; start_frame(); end_frame();
    chk("basic_frames", frames, f0 + 1);
    chk("basic_cs_low", cs_cnt, 1452);
    chk("basic_sclk_pmin", pmin, 12);
    chk("basic_sclk_pmax", pmax, 12);
    chk("basic_mosi_w0", 32'(mosi_w0), 32'h0);
    chk("basic_mosi_rest", mosi_ones, 0);
    chk("basic_overrun", 32'(overrun), 32'd0);
    chk("basic_sq_empty", sq.size(), 0);

    cmd = 16'h0655;
    set_frame(16'h1234, 24'h123456, 24'hFEDCBA, 24'h000000, 24'hFFFFFF, 1);
    start_frame(); cmd = 16'h0000; end_frame();
    chk("cmd_mosi_w0", 32'(mosi_w0), 32'h065500);
    chk("cmd_mosi_rest", mosi_ones, 0);
    chk("cmd_sq_empty", sq.size(), 0);

    ready = 0;
    set_frame(16'h2200, 24'h000001, 24'h7FFFFF, 24'h800000, 24'hABCDEF, 0);
    stq.push_back(16'h2200);
    start_frame(); end_frame();
    chk("bp_overrun", 32'(overrun), 32'd1);
    chk("bp_valid_held", 32'(sample_valid), 32'd1);
    sq.push_back({3'd3, 24'hABCDEF});
    ready = 1; tick(3);
    chk("bp_sq_empty", sq.size(), 0);
    chk("bp_valid_drop", 32'(sample_valid), 32'd0);

    do_reset();
    chk("miss_overrun_clr", 32'(overrun), 32'd0);
    set_frame(16'h2200, 24'h000001, 24'h7FFFFF, 24'h800000, 24'hABCDEF, 1);
    f0 = frames;
    start_frame(); tick(300);
    drdy_n = 0; tick(20); drdy_n = 1;
    end_frame();
    chk("miss_frames", frames, f0 + 1);
    chk("miss_cs_low", cs_cnt, 1452);
    chk("miss_overrun", 32'(overrun), 32'd1);
    tick(50);
    chk("miss_no_restart", frames, f0 + 1);
    set_frame(16'h0F0F, 24'h111111, 24'h222222, 24'h333333, 24'h444444, 1);
    start_frame(); end_frame();
    chk("miss_next_frames", frames, f0 + 2);
    chk("miss_next_cs_low", cs_cnt, 1452);

    do_reset();
    set_frame(16'h5A5A, 24'h0A0A0A, 24'h0B0B0B, 24'h0C0C0C, 24'h0D0D0D, 0);
    stq.push_back(16'h5A5A);
    start_frame(); tick(498);
    rst = 1; #1;
    chk("mid_rst_cs", 32'(cs), 32'd1);
    chk("mid_rst_sclk", 32'(sclk), 32'd0);
    chk("mid_rst_valid", 32'(sample_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_status_seen", stq.size(), 0);
    tick(2); rst = 0; tick(3);
    set_frame(16'h2200, 24'h000001, 24'h7FFFFF, 24'h800000, 24'hABCDEF, 1);
    f0 = frames; start_frame(); end_frame();
    chk("post_rst_frames", frames, f0 + 1);
    chk("post_rst_cs_low", cs_cnt, 1452);
    chk("post_rst_sq_empty", sq.size(), 0);

    enable = 0; f0 = frames;
    repeat (2) begin drdy_n = 0; tick(20); drdy_n = 1; tick(20); end
    chk("en_low_frames", frames, f0);
    chk("en_low_cs", 32'(cs), 32'd1);
    chk("en_low_overrun", 32'(overrun), 32'd0);

    chk("final_stq_empty", stq.size(), 0);
    chk("final_sq_empty", sq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
